alu_muldiv: RTL and testbench
=============================

# alu_muldiv

Iterative 8×8 multiply / 8÷8 divide unit beside the ALU. It takes the same two operands: A from the A register and B from the data bus. Results go back onto the shared bus through tri-state transmitters. Microcode starts an operation with a one-cycle pulse, waits on `o_busy`, then reads the low and high result bytes in separate bus cycles.

## Interface
Parameters:
- `WIDTH`, 8, operand width; result is 2×`WIDTH` and iteration count is `WIDTH`.

Ports:
- `i_clk`  in  1  clock; all state changes on the rising edge.
- `i_reset`  in  1  reset; synchronous, active-high.
- `i_a`  in  8  operand A: multiplicand or dividend.
- `i_bus`  in  8  operand B: multiplier or divisor, sampled from the bus.
- `o_bus`  out  8  tri-state bus drive; high-Z unless an output enable is low.
- `i_ctrlMdStart`  in  1  active-high start strobe.
- `i_ctrlMdDiv`  in  1  operation select, sampled with start: 0 = multiply, 1 = divide.
- `i_ctrlMdLoNOE`  in  1  active-low enable; drives the low result byte onto the bus.
- `i_ctrlMdHiNOE`  in  1  active-low enable; drives the high result byte onto the bus.
- `o_busy`  out  1  high while iterating.
- `o_done`  out  1  one-cycle pulse after completion.
- `o_flagNZero`  out  1  high when the 16-bit result {hi,lo} is non-zero.
- `o_flagDivZero`  out  1  high when the last divide had divisor 0.

## Operation
- States: IDLE and RUN.
  - IDLE → RUN on a start edge. At that edge, capture `i_a`, `i_bus` and `i_ctrlMdDiv`, and clear the 3-bit iteration counter.
  - RUN performs one iteration per edge. On the 8th RUN edge it writes the result registers, sets `o_done` and returns to IDLE.
- Multiply: unsigned shift-and-add. The accumulator is 16 bits with no overflow possible. Result: lo = product[7:0], hi = product[15:8].
- Divide: unsigned restoring division, one quotient bit per iteration, MSB first. Result: lo = quotient, hi = remainder.
- Divisor 0: no special path and the full 8 iterations still run. The result is quotient 0xFF, remainder = dividend, and `o_flagDivZero` is set. `o_flagDivZero` is cleared by any completion that is not a divide-by-zero.
- Result registers change only at completion. Reads during RUN return the previous result.
- Flags are derived from the result registers and are stable between completions.
- Start while busy: ignored; operands are not re-captured.
- Start coinciding with `o_done`: accepted, because the unit is IDLE that cycle.
- Both enables low: the low byte wins and the high byte is suppressed, so there is never a bus contention inside the unit.
- Operands on `i_a`/`i_bus` may change freely after the start edge.

## Timing
- Start edge E0. Iterations at E1..E8. `o_busy` is high from after E0 through E8.
- Results and flags are valid after E8. `o_done` is high between E8 and E9.
- Start-to-readable latency: 9 edges.
- `o_bus` is combinational from the enables and the result registers: same-cycle drive, the same bus timing as the ALU output.
- Reset values:
  - state IDLE, counter 0;
  - result registers 0x0000;
  - `o_busy` 0, `o_done` 0, `o_flagNZero` 0, `o_flagDivZero` 0;
  - `o_bus` high-Z.
- Reset during RUN: the operation is aborted at that edge, no result is written, and all outputs take their reset values. Reset overrides a simultaneous start.

## Configuration
- `ALU_MULDIV_DIV_EN` defined: divide is implemented as specified above.
- `ALU_MULDIV_DIV_EN` not defined:
  - no divider logic is built;
  - `i_ctrlMdDiv` is ignored and every start performs a multiply;
  - `o_flagDivZero` is tied to 0.
  - Timing is unchanged.

## Structure
- Shared package `alu_muldiv_pkg` holds:
  - the state enum (IDLE, RUN);
  - the operation enum (OP_MUL, OP_DIV);
  - `MD_ITER = 8`;
  - the divide-by-zero quotient constant 0xFF.
- Sub-module: the existing `transmitter` cell, two instances (low and high byte) sharing `o_bus`. The enable muxing above guarantees at most one instance is active at a time.
- The datapath step (add/shift or subtract/compare) stays inline.

## Test plan
- 13 × 11: start with A=0x0D, bus=0x0B, div=0 → `o_busy` for 8 cycles, then `o_done` pulse; lo=0x8F, hi=0x00, `o_flagNZero`=1.
- 0xFF × 0xFF → lo=0x01, hi=0xFE. Then 0x00 × 0x37 → result 0x0000, `o_flagNZero`=0.
- 200 ÷ 7 (A=0xC8, bus=0x07, div=1) → lo=0x1C, hi=0x04, `o_flagDivZero`=0.
- 0x5A ÷ 0 → lo=0xFF, hi=0x5A, `o_flagDivZero`=1. A following 0x10 ÷ 0x04 → lo=0x04, hi=0x00, `o_flagDivZero`=0.
- Second start 3 cycles into RUN with different operands → ignored; the first result is delivered at E8. Reading lo/hi during RUN returns the prior result; both enables low drives the lo byte only.
- `i_reset` at E4 of a multiply → `o_busy`=0, result 0x0000, `o_bus` high-Z. A new start at E5 completes normally at E13.

Source files
------------

// File: rtl/alu_muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package alu_muldiv_pkg;

    typedef enum logic {IDLE, RUN} state_t;
    typedef enum logic {OP_MUL, OP_DIV} op_t;

    localparam int         MD_ITER       = 8;
    localparam logic [7:0] DIV_ZERO_QUOT = 8'hFF;

endpackage

// File: rtl/alu_muldiv_transmitter.sv
// Tri-state bus transmitter cell: drives the shared bus only while enabled.
module transmitter #(
    parameter int WIDTH = 8
) (
    input  logic             en,
    input  logic [WIDTH-1:0] data,
    output wire  [WIDTH-1:0] bus
);

    assign bus = en ? data : 'z;

endmodule

// File: rtl/alu_muldiv.sv
// Iterative WIDTHxWIDTH multiply / divide unit with tri-state result readback.
// Divide is built only when ALU_MULDIV_DIV_EN is defined; otherwise every start multiplies.
module alu_muldiv
    import alu_muldiv_pkg::*;
#(
    parameter int WIDTH = MD_ITER
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_bus,
    output wire  [WIDTH-1:0] o_bus,
    input  logic             i_ctrlMdStart,
    input  logic             i_ctrlMdDiv,
    input  logic             i_ctrlMdLoNOE,
    input  logic             i_ctrlMdHiNOE,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_flagNZero,
    output logic             o_flagDivZero
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] op_reg, work_hi, work_lo;
    logic [WIDTH-1:0] step_hi, step_lo;
    logic [WIDTH-1:0] res_lo, res_hi;
    logic [WIDTH:0]   sum;
    logic             start_ok, last_iter, done, div_sel, is_div;

`ifdef ALU_MULDIV_DIV_EN
    op_t            op;
    logic           div_zero;
    logic [WIDTH:0] rem_try, rem_diff;

    assign div_sel       = i_ctrlMdDiv;
    assign is_div        = (op == OP_DIV);
    assign o_flagDivZero = div_zero;
`else
    logic unused_div;

    assign unused_div    = i_ctrlMdDiv;
    assign div_sel       = 1'b0;
    assign is_div        = 1'b0;
    assign o_flagDivZero = 1'b0;
`endif

    assign start_ok  = (state == IDLE) && i_ctrlMdStart;
    assign last_iter = (state == RUN) && (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge i_clk) begin
        if (i_reset) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_ctrlMdStart) state_next = RUN;
            RUN:     if (last_iter)     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Multiply shifts {hi,lo} right with the multiplier draining out of lo;
    // divide shifts left with dividend bits leaving lo and quotient bits entering it.
    always_comb begin
        sum     = {1'b0, work_hi} + (work_lo[0] ? {1'b0, op_reg} : '0);
        step_hi = sum[WIDTH:1];
        step_lo = {sum[0], work_lo[WIDTH-1:1]};
`ifdef ALU_MULDIV_DIV_EN
        rem_try  = {work_hi, work_lo[WIDTH-1]};
        rem_diff = rem_try - {1'b0, op_reg};
        // No borrow means the trial remainder covered the divisor.
        if (is_div) begin
            step_hi = rem_diff[WIDTH] ? rem_try[WIDTH-1:0] : rem_diff[WIDTH-1:0];
            step_lo = {work_lo[WIDTH-2:0], ~rem_diff[WIDTH]};
        end
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt     <= '0;
            op_reg  <= '0;
            work_hi <= '0;
            work_lo <= '0;
            res_lo  <= '0;
            res_hi  <= '0;
            done    <= 1'b0;
`ifdef ALU_MULDIV_DIV_EN
            op       <= OP_MUL;
            div_zero <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (start_ok) begin
                cnt     <= '0;
                work_hi <= '0;
                op_reg  <= div_sel ? i_bus : i_a;
                work_lo <= div_sel ? i_a : i_bus;
`ifdef ALU_MULDIV_DIV_EN
                op <= div_sel ? OP_DIV : OP_MUL;
`endif
            end else if (state == RUN) begin
                cnt     <= cnt + CNT_W'(1);
                work_hi <= step_hi;
                work_lo <= step_lo;
                if (last_iter) begin
                    res_lo <= step_lo;
                    res_hi <= step_hi;
                    done   <= 1'b1;
`ifdef ALU_MULDIV_DIV_EN
                    div_zero <= is_div && (op_reg == '0);
`endif
                end
            end
        end
    end

    assign o_busy      = (state == RUN);
    assign o_done      = done;
    assign o_flagNZero = |{res_hi, res_lo};

    // Low byte wins when both enables are asserted, so the two cells never fight.
    transmitter #(.WIDTH(WIDTH)) u_tx_lo (
        .en   (~i_ctrlMdLoNOE),
        .data (res_lo),
        .bus  (o_bus)
    );

    transmitter #(.WIDTH(WIDTH)) u_tx_hi (
        .en   (~i_ctrlMdHiNOE & i_ctrlMdLoNOE),
        .data (res_hi),
        .bus  (o_bus)
    );

endmodule

// File: tb/tb_alu_muldiv.sv
// Scoreboard bench for alu_muldiv: expected results are queued at start and checked at done.
module tb_alu_muldiv;
    import alu_muldiv_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1, start = 1'b0, div = 1'b0, lo_n = 1'b1, hi_n = 1'b1;
    logic [7:0] a = '0, b = '0;
    wire  [7:0] bus;
    logic       busy, done, nz, dz;

    typedef struct packed {
        logic [7:0] lo;
        logic [7:0] hi;
        logic       dz;
    } exp_t;

    exp_t sb[$];
    exp_t last;
    int   n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;

    alu_muldiv #(.WIDTH(8)) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_a           (a),
        .i_bus         (b),
        .o_bus         (bus),
        .i_ctrlMdStart (start),
        .i_ctrlMdDiv   (div),
        .i_ctrlMdLoNOE (lo_n),
        .i_ctrlMdHiNOE (hi_n),
        .o_busy        (busy),
        .o_done        (done),
        .o_flagNZero   (nz),
        .o_flagDivZero (dz)
    );

    function automatic exp_t model(input logic [7:0] x, input logic [7:0] y, input logic d);
        exp_t        e;
        logic [15:0] p;
        p    = {8'h00, x} * {8'h00, y};
        e.lo = p[7:0];
        e.hi = p[15:8];
        e.dz = 1'b0;
`ifdef ALU_MULDIV_DIV_EN
        if (d) begin
            if (y == 8'h00) begin
                e.lo = DIV_ZERO_QUOT;
                e.hi = x;
                e.dz = 1'b1;
            end else begin
                e.lo = x / y;
                e.hi = x % y;
            end
        end
`else
        if (d) e.dz = 1'b0;
`endif
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [7:0] x, input logic [7:0] y, input logic d, input logic push);
        a = x; b = y; div = d; start = 1'b1;
        if (push) sb.push_back(model(x, y, d));
        tick();
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom); div = 1'($urandom);
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            if (busy) cyc++;
            tick();
        end
        if (!done) begin
            n_tests++; n_fail++;
            $display("FAIL wait_done timeout: done=%b after 20 cycles, want 1", done);
        end
    endtask

    task automatic read_bus(input logic ln, input logic hn, output logic [7:0] v);
        lo_n = ln; hi_n = hn;
        #1 v = bus;
        lo_n = 1'b1; hi_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [7:0] v, zz;
        zz = 'z;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy got %b want 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset done got %b want 0", done); end
        n_tests++; if (nz !== 1'b0) begin n_fail++; $display("FAIL reset nzero got %b want 0", nz); end
        n_tests++; if (dz !== 1'b0) begin n_fail++; $display("FAIL reset divzero got %b want 0", dz); end
        read_bus(1'b1, 1'b1, v);
        n_tests++; if (v !== zz) begin n_fail++; $display("FAIL reset bus got %h want zz", v); end
        read_bus(1'b0, 1'b1, v);
        n_tests++; if (v !== 8'h00) begin n_fail++; $display("FAIL reset lo got %h want 00", v); end
        // Reset wins over a simultaneous start.
        reset = 1'b1; start = 1'b1; a = 8'h05; b = 8'h05;
        tick();
        reset = 1'b0; start = 1'b0;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_vs_start busy got %b want 0", busy); end
        last = '0;
    endtask

    task automatic test_mul();
        logic [7:0] ta[3] = '{8'h0D, 8'hFF, 8'h00};
        logic [7:0] tb[3] = '{8'h0B, 8'hFF, 8'h37};
        logic [7:0] v;
        int         cyc;
        exp_t       e;
        for (int i = 0; i < 3; i++) begin
            start_op(ta[i], tb[i], 1'b0, 1'b1);
            wait_done(cyc);
            e = sb.pop_front();
            n_tests++; if (cyc != 8) begin n_fail++; $display("FAIL mul%0d busy cycles got %0d want 8", i, cyc); end
            read_bus(1'b0, 1'b1, v);
            n_tests++; if (v !== e.lo) begin n_fail++; $display("FAIL mul%0d lo got %h want %h", i, v, e.lo); end
            read_bus(1'b1, 1'b0, v);
            n_tests++; if (v !== e.hi) begin n_fail++; $display("FAIL mul%0d hi got %h want %h", i, v, e.hi); end
            n_tests++; if (nz !== (|{e.hi, e.lo})) begin n_fail++; $display("FAIL mul%0d nzero got %b want %b", i, nz, |{e.hi, e.lo}); end
            n_tests++; if (dz !== e.dz) begin n_fail++; $display("FAIL mul%0d divzero got %b want %b", i, dz, e.dz); end
            tick();
            n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL mul%0d done width got %b want 0", i, done); end
            last = e;
        end
    endtask

    task automatic test_div();
        logic [7:0] ta[3] = '{8'hC8, 8'h5A, 8'h10};
        logic [7:0] tb[3] = '{8'h07, 8'h00, 8'h04};
        logic [7:0] v;
        int         cyc;
        exp_t       e;
        for (int i = 0; i < 3; i++) begin
            start_op(ta[i], tb[i], 1'b1, 1'b1);
            wait_done(cyc);
            e = sb.pop_front();
            n_tests++; if (cyc != 8) begin n_fail++; $display("FAIL div%0d busy cycles got %0d want 8", i, cyc); end
            read_bus(1'b0, 1'b1, v);
            n_tests++; if (v !== e.lo) begin n_fail++; $display("FAIL div%0d lo got %h want %h", i, v, e.lo); end
            read_bus(1'b1, 1'b0, v);
            n_tests++; if (v !== e.hi) begin n_fail++; $display("FAIL div%0d hi got %h want %h", i, v, e.hi); end
            n_tests++; if (nz !== (|{e.hi, e.lo})) begin n_fail++; $display("FAIL div%0d nzero got %b want %b", i, nz, |{e.hi, e.lo}); end
            n_tests++; if (dz !== e.dz) begin n_fail++; $display("FAIL div%0d divzero got %b want %b", i, dz, e.dz); end
            last = e;
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] v;
        int         cyc;
        exp_t       e;
        start_op(8'h0D, 8'h0B, 1'b0, 1'b1);
        tick(); tick();
        start_op(8'h22, 8'h33, 1'b0, 1'b0);
        read_bus(1'b0, 1'b1, v);
        n_tests++; if (v !== last.lo) begin n_fail++; $display("FAIL run_read lo got %h want %h", v, last.lo); end
        read_bus(1'b1, 1'b0, v);
        n_tests++; if (v !== last.hi) begin n_fail++; $display("FAIL run_read hi got %h want %h", v, last.hi); end
        read_bus(1'b0, 1'b0, v);
        n_tests++; if (v !== last.lo) begin n_fail++; $display("FAIL both_low bus got %h want %h", v, last.lo); end
        wait_done(cyc);
        n_tests++; if (cyc != 5) begin n_fail++; $display("FAIL ignored_start busy tail got %0d want 5", cyc); end
        e = sb.pop_front();
        read_bus(1'b0, 1'b1, v);
        n_tests++; if (v !== e.lo) begin n_fail++; $display("FAIL ignored_start lo got %h want %h", v, e.lo); end
        read_bus(1'b1, 1'b0, v);
        n_tests++; if (v !== e.hi) begin n_fail++; $display("FAIL ignored_start hi got %h want %h", v, e.hi); end
        // Start in the done cycle is accepted.
        start_op(8'h07, 8'h06, 1'b0, 1'b1);
        wait_done(cyc);
        e = sb.pop_front();
        n_tests++; if (cyc != 8) begin n_fail++; $display("FAIL start_on_done busy cycles got %0d want 8", cyc); end
        read_bus(1'b0, 1'b1, v);
        n_tests++; if (v !== e.lo) begin n_fail++; $display("FAIL start_on_done lo got %h want %h", v, e.lo); end
        read_bus(1'b1, 1'b0, v);
        n_tests++; if (v !== e.hi) begin n_fail++; $display("FAIL start_on_done hi got %h want %h", v, e.hi); end
        last = e;
    endtask

    task automatic test_reset_mid_run();
        logic [7:0] v, zz;
        int         cyc;
        exp_t       e;
        zz = 'z;
        start_op(8'h99, 8'h77, 1'b0, 1'b0);
        tick(); tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort busy got %b want 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort done got %b want 0", done); end
        n_tests++; if (nz !== 1'b0) begin n_fail++; $display("FAIL abort nzero got %b want 0", nz); end
        read_bus(1'b0, 1'b1, v);
        n_tests++; if (v !== 8'h00) begin n_fail++; $display("FAIL abort lo got %h want 00", v); end
        read_bus(1'b1, 1'b1, v);
        n_tests++; if (v !== zz) begin n_fail++; $display("FAIL abort bus got %h want zz", v); end
        start_op(8'h12, 8'h34, 1'b0, 1'b1);
        wait_done(cyc);
        e = sb.pop_front();
        n_tests++; if (cyc != 8) begin n_fail++; $display("FAIL post_abort busy cycles got %0d want 8", cyc); end
        read_bus(1'b0, 1'b1, v);
        n_tests++; if (v !== e.lo) begin n_fail++; $display("FAIL post_abort lo got %h want %h", v, e.lo); end
        read_bus(1'b1, 1'b0, v);
        n_tests++; if (v !== e.hi) begin n_fail++; $display("FAIL post_abort hi got %h want %h", v, e.hi); end
        n_tests++; if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard leftover got %0d want 0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_back_to_back();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
